// File: rtl/ripple_carry_8bit_serial_if.sv
// rtl/ripple_carry_8bit_serial_if.sv - serial operand/result bundle for the bit-serial adder
//
// Signals:
//   cin  - carry-in for a word, only meaningful on bit 0
//   a    - serial operand A bit, LSB first
//   b    - serial operand B bit, LSB first
//   sum  - registered serial sum bit, LSB first
//   cout - registered one-cycle carry-out pulse on the last bit of a word
//
// Modports:
//   master - operand source / result sink (drives cin, a, b)
//   slave  - the adder (drives sum, cout)

interface ripple_carry_8bit_serial_if;
    logic cin;
    logic a;
    logic b;
    logic sum;
    logic cout;

    modport master (
        output cin,
        output a,
        output b,
        input  sum,
        input  cout
    );

    modport slave (
        input  cin,
        input  a,
        input  b,
        output sum,
        output cout
    );
endinterface

// File: rtl/ripple_carry_8bit_serial.sv
// rtl/ripple_carry_8bit_serial.sv - bit-serial ripple-carry adder, LSB first
//
// Parameters:
//   WIDTH - bits per operand word; sets the bit-counter wrap point
//
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of the serial operand/result bundle
//           (cin, a, b in; sum, cout out)
//
// Words run back-to-back with no idle cycles; the first word begins on the
// first rising edge after reset release. Both outputs come straight from
// flops, so there is no combinational path from any input to sum or cout.

module ripple_carry_8bit_serial #(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ripple_carry_8bit_serial_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;
    logic          carry_q;
    logic          sum_q;
    logic          cout_q;

    logic          is_first;
    logic          is_last;
    logic          c_eff;
    logic          s_next;
    logic          c_next;
    logic [CW-1:0] cnt_next;
    logic          cout_next;

    always_comb begin
        is_first  = (cnt == '0);
        is_last   = (cnt == LAST);
        // Bit 0 always takes the word's cin so a previous word's carry can
        // never ripple into the next word.
        c_eff     = is_first ? bus.cin : carry_q;
        s_next    = bus.a ^ bus.b ^ c_eff;
        c_next    = (bus.a & bus.b) | (bus.a & c_eff) | (bus.b & c_eff);
        cout_next = is_last ? c_next : 1'b0;
        cnt_next  = is_last ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            carry_q <= 1'b0;
            sum_q   <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            carry_q <= c_next;
            sum_q   <= s_next;
            cout_q  <= cout_next;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_ripple_carry_8bit_serial.sv
// tb/tb_ripple_carry_8bit_serial.sv - directed self-checking bench for ripple_carry_8bit_serial

module tb_ripple_carry_8bit_serial;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ripple_carry_8bit_serial_if bus ();

    ripple_carry_8bit_serial #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Drive one bit, let the rising edge take it, then sample 1 time unit later.
    task automatic step(input logic a_bit, input logic b_bit, input logic cin_bit);
        bus.a   = a_bit;
        bus.b   = b_bit;
        bus.cin = cin_bit;
        @(posedge clk);
        #1;
    endtask

    // cin_bits[0] is the word's carry-in; bits 7:1 are driven onto cin during
    // the remaining bit slices and must have no effect.
    task automatic send_word(input string tag, input logic [7:0] a_w, input logic [7:0] b_w,
                             input logic [7:0] cin_bits, input logic [7:0] exp_sum,
                             input logic exp_cout);
        for (int i = 0; i < 8; i++) begin
            step(a_w[i], b_w[i], cin_bits[i]);
            check($sformatf("%s sum[%0d]", tag, i), bus.sum, exp_sum[i]);
            check($sformatf("%s cout[%0d]", tag, i), bus.cout, (i == 7) ? exp_cout : 1'b0);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        bus.a   = 1'b0;
        bus.b   = 1'b0;
        bus.cin = 1'b0;
        rst_n   = 1'b0;

        // 1. Reset state, and reset holds through clock edges with active inputs.
        #2;
        check("reset sum", bus.sum, 1'b0);
        check("reset cout", bus.cout, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("reset hold sum", bus.sum, 1'b0);
        check("reset hold cout", bus.cout, 1'b0);
        #3 rst_n = 1'b1;

        // 2. First edge after release is bit 0: 0x01 + 0x01 = 0x02.
        send_word("w1p1", 8'h01, 8'h01, 8'h00, 8'h02, 1'b0);

        // 3. 0xFF + 0x01 = 0x100: sum 0x00, cout pulse on bit 7 only.
        send_word("wffp1", 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1);

        // 4. 0x00 + 0x00, cin=1 on bit 0, cin toggling on bits 1-7 -> 0x01.
        send_word("cin_only_b0", 8'h00, 8'h00, 8'b1010_1011, 8'h01, 1'b0);

        // 5. 0xAA + 0x55 + 1 = 0x100, then 0x03 + 0x05 = 0x08 with no carry leak.
        send_word("waa55", 8'hAA, 8'h55, 8'h01, 8'h00, 1'b1);
        send_word("w0305", 8'h03, 8'h05, 8'h00, 8'h08, 1'b0);

        // 6. 0xFF + 0xFF, reset after bit 4. Sum bits 0..4 of 0x1FE: 0,1,1,1,1.
        step(1'b1, 1'b1, 1'b0);
        check("ffff sum[0]", bus.sum, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("ffff sum[1]", bus.sum, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("ffff sum[4]", bus.sum, 1'b1);
        check("ffff cout[4]", bus.cout, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midword reset sum", bus.sum, 1'b0);
        check("midword reset cout", bus.cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        send_word("w1010", 8'h10, 8'h10, 8'h00, 8'h20, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
